// File: rtl/dht_poller.sv
// Polls DHT-style single-wire sensors: host start pulse, response handshake, 40-bit MSB-first read, checksum, retries.
// All timing is counted in 1 us ticks from a prescaler that restarts on every state change.
module dht_poller #(
    parameter int N_SENSORS    = 32,
    parameter int CLK_PER_US   = 50,
    parameter int START_LOW_US = 19000,
    parameter int MAX_RETRY    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    inout  wire  [N_SENSORS-1:0] dht_data,
    input  logic                 start,
    input  logic [4:0]           sensor_index,
    input  logic                 auto_scan,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           error_code,
    output logic [4:0]           result_index,
    output logic [7:0]           hum_int,
    output logic [7:0]           hum_float,
    output logic [7:0]           temp_int,
    output logic [7:0]           temp_float,
    output logic [7:0]           check_sum
);
    localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int UW = ($clog2(START_LOW_US + 1) > 8) ? $clog2(START_LOW_US + 1) : 8;

    localparam int RELEASE_US    = 20;
    localparam int RESP_WAIT_US  = 40;
    localparam int RESP_US       = 100;
    localparam int BIT_LOW_US    = 70;
    localparam int BIT_HIGH_US   = 100;
    localparam int ONE_THRESH_US = 50;
    localparam int RECOVER_US    = 100;

    typedef enum logic [3:0] {
        IDLE, START_LOW, RELEASE, WAIT_RESP, RESP_LOW, RESP_HIGH,
        BIT_LOW, BIT_HIGH, CHECK, RECOVER, REPORT
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0] pre_cnt;
    logic [UW-1:0] us_cnt;
    logic          tick;
    logic [4:0]    tgt_idx;
    logic [4:0]    scan_ptr;
    logic [4:0]    latch_idx;
    logic          scan_txn;
    logic          retry_pend;
    logic [1:0]    retry_cnt;
    logic [1:0]    last_code;
    logic [1:0]    fail_code;
    logic [1:0]    rep_code;
    logic          fail;
    logic          latch;
    logic          load_rep;
    logic          shift_en;
    logic          bit_val;
    logic          idx_bad;
    logic          sync1, sync2;
    logic [31:0]   line_in;
    logic [39:0]   shift_reg;
    logic [5:0]    bit_cnt;
    logic [7:0]    sum8;

    // Open-drain: only the targeted line is ever pulled low, and only during the start pulse.
    for (genvar i = 0; i < N_SENSORS; i++) begin : g_drive
        assign dht_data[i] = (state == START_LOW && tgt_idx == 5'(i)) ? 1'b0 : 1'bz;
    end

    assign line_in   = 32'(dht_data);
    assign tick      = (pre_cnt == PW'(CLK_PER_US - 1));
    assign idx_bad   = ({1'b0, sensor_index} >= 6'(N_SENSORS));
    assign latch_idx = auto_scan ? scan_ptr : sensor_index;
    assign sum8      = shift_reg[39:32] + shift_reg[31:24] + shift_reg[23:16] + shift_reg[15:8];
    assign busy      = (state != IDLE);
    assign done      = (state == REPORT);

    function automatic logic expired(input logic [UW-1:0] cnt, input logic tk, input int lim_us);
        return tk && (cnt == UW'(lim_us - 1));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        fail      = 1'b0;
        fail_code = 2'd0;
        load_rep  = 1'b0;
        rep_code  = last_code;
        shift_en  = 1'b0;
        bit_val   = (us_cnt > UW'(ONE_THRESH_US));
        case (state)
            IDLE: begin
                if (auto_scan || start) begin
                    latch = 1'b1;
                    if (!auto_scan && idx_bad) begin
                        state_nxt = REPORT;
                        load_rep  = 1'b1;
                        rep_code  = 2'd3;
                    end else begin
                        state_nxt = START_LOW;
                    end
                end
            end
            START_LOW: if (expired(us_cnt, tick, START_LOW_US)) state_nxt = RELEASE;
            RELEASE:   if (expired(us_cnt, tick, RELEASE_US))   state_nxt = WAIT_RESP;
            WAIT_RESP: begin
                if (!sync2) state_nxt = RESP_LOW;
                else if (expired(us_cnt, tick, RESP_WAIT_US)) begin
                    fail      = 1'b1;
                    fail_code = 2'd1;
                end
            end
            RESP_LOW: begin
                if (sync2) state_nxt = RESP_HIGH;
                else if (expired(us_cnt, tick, RESP_US)) begin
                    fail      = 1'b1;
                    fail_code = 2'd1;
                end
            end
            RESP_HIGH: begin
                if (!sync2) state_nxt = BIT_LOW;
                else if (expired(us_cnt, tick, RESP_US)) begin
                    fail      = 1'b1;
                    fail_code = 2'd1;
                end
            end
            BIT_LOW: begin
                if (sync2) state_nxt = BIT_HIGH;
                else if (expired(us_cnt, tick, BIT_LOW_US)) begin
                    fail      = 1'b1;
                    fail_code = 2'd1;
                end
            end
            BIT_HIGH: begin
                // Falling edge ends the bit; its high time decides the value.
                if (!sync2) begin
                    shift_en  = 1'b1;
                    state_nxt = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
                end else if (expired(us_cnt, tick, BIT_HIGH_US)) begin
                    fail      = 1'b1;
                    fail_code = 2'd1;
                end
            end
            CHECK: begin
                if (sum8 == shift_reg[7:0]) begin
                    state_nxt = REPORT;
                    load_rep  = 1'b1;
                    rep_code  = 2'd0;
                end else begin
                    fail      = 1'b1;
                    fail_code = 2'd2;
                end
            end
            RECOVER: begin
                if (expired(us_cnt, tick, RECOVER_US)) begin
                    if (retry_pend) begin
                        state_nxt = START_LOW;
                    end else begin
                        state_nxt = REPORT;
                        load_rep  = 1'b1;
                    end
                end
            end
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (fail) state_nxt = RECOVER;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt      <= '0;
            us_cnt       <= '0;
            sync1        <= 1'b1;
            sync2        <= 1'b1;
            tgt_idx      <= 5'd0;
            scan_ptr     <= 5'd0;
            scan_txn     <= 1'b0;
            retry_cnt    <= 2'd0;
            retry_pend   <= 1'b0;
            last_code    <= 2'd0;
            shift_reg    <= 40'd0;
            bit_cnt      <= 6'd0;
            error        <= 1'b0;
            error_code   <= 2'd0;
            result_index <= 5'd0;
            hum_int      <= 8'h00;
            hum_float    <= 8'h00;
            temp_int     <= 8'h00;
            temp_float   <= 8'h00;
            check_sum    <= 8'h00;
        end else begin
            sync1 <= line_in[tgt_idx];
            sync2 <= sync1;

            if (state_nxt != state) begin
                pre_cnt <= '0;
                us_cnt  <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
                us_cnt  <= us_cnt + UW'(1);
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end

            if (latch) begin
                tgt_idx    <= latch_idx;
                scan_txn   <= auto_scan;
                retry_cnt  <= 2'd0;
                retry_pend <= 1'b0;
            end

            if (fail) begin
                last_code <= fail_code;
                if (int'(retry_cnt) < MAX_RETRY) begin
                    retry_cnt  <= retry_cnt + 2'd1;
                    retry_pend <= 1'b1;
                end else begin
                    retry_pend <= 1'b0;
                end
            end

            // Every attempt starts with an empty shift register.
            if (latch || (state_nxt == START_LOW && state != START_LOW)) begin
                shift_reg <= 40'd0;
                bit_cnt   <= 6'd0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[38:0], bit_val};
                bit_cnt   <= bit_cnt + 6'd1;
            end

            if (load_rep) begin
                error        <= (rep_code != 2'd0);
                error_code   <= rep_code;
                result_index <= latch ? latch_idx : tgt_idx;
                {hum_int, hum_float, temp_int, temp_float, check_sum} <=
                    (rep_code == 2'd3) ? 40'd0 : shift_reg;
            end

            if (state == REPORT && scan_txn) begin
                scan_ptr <= (scan_ptr == 5'(N_SENSORS - 1)) ? 5'd0 : scan_ptr + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_dht_poller.sv
// Directed bench for dht_poller with a behavioural multi-line sensor model on pulled-up open-drain lines.
module tb_dht_poller;
    localparam int NS  = 4;
    localparam int CPU = 2;
    localparam int SLU = 50;
    localparam int MR  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [4:0]    sensor_index;
    logic          auto_scan;
    wire  [NS-1:0] dht_data;
    logic          busy, done, error;
    logic [1:0]    error_code;
    logic [4:0]    result_index;
    logic [7:0]    hum_int, hum_float, temp_int, temp_float, check_sum;

    logic [NS-1:0] sens_low = '0;
    logic [NS-1:0] host_low;
    logic [39:0]   frames [NS];
    logic          corrupt_once = 1'b0;
    int            mdl_line = -1;
    int            mdl_bits = 0;

    int n_vec = 0;
    int n_err = 0;
    int pulses [NS] = '{default: 0};
    int cur_len [NS] = '{default: 0};
    int bad_len = 0;
    int host_low_cyc = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NS; g++) begin : g_line
        assign dht_data[g] = sens_low[g] ? 1'b0 : 1'bz;
        pullup pu (dht_data[g]);
        assign host_low[g] = (dht_data[g] == 1'b0) && !sens_low[g];
    end

    dht_poller #(
        .N_SENSORS   (NS),
        .CLK_PER_US  (CPU),
        .START_LOW_US(SLU),
        .MAX_RETRY   (MR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dht_data    (dht_data),
        .start       (start),
        .sensor_index(sensor_index),
        .auto_scan   (auto_scan),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .error_code  (error_code),
        .result_index(result_index),
        .hum_int     (hum_int),
        .hum_float   (hum_float),
        .temp_int    (temp_int),
        .temp_float  (temp_float),
        .check_sum   (check_sum)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_us(input int n);
        repeat (n * CPU) @(negedge clk);
    endtask

    task automatic go(input logic [4:0] idx);
        @(negedge clk);
        sensor_index = idx;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output logic ok);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        ok = done;
    endtask

    // Host start pulses: count them and flag any whose length is not exactly the start-low time.
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (host_low[i]) begin
                if (cur_len[i] == 0) pulses[i]++;
                cur_len[i]++;
                host_low_cyc++;
            end else if (cur_len[i] != 0) begin
                if (cur_len[i] != SLU * CPU) bad_len++;
                cur_len[i] = 0;
            end
        end
    end

    // Sensor model: line 2 is silent; 0 -> 20 us high, 1 -> 60 us high; corrupt_once spoils one checksum on line 3.
    initial begin
        logic [39:0] fr;
        int          ln;
        frames[0] = 40'h40_05_1A_03_62;
        frames[1] = 40'h2D_00_16_08_4B;
        frames[2] = 40'h00_00_00_00_00;
        frames[3] = 40'h37_00_19_00_50;
        forever begin
            @(negedge clk);
            if (host_low != '0) begin
                ln = 0;
                for (int i = NS - 1; i >= 0; i--) if (host_low[i]) ln = i;
                while (host_low[ln]) @(negedge clk);
                if (ln != 2) begin
                    fr = frames[ln];
                    if (ln == 3 && corrupt_once) begin
                        fr[7:0]      = 8'h51;
                        corrupt_once = 1'b0;
                    end
                    mdl_line = ln;
                    mdl_bits = 0;
                    wait_us(30);
                    sens_low[ln] = 1'b1;
                    wait_us(80);
                    sens_low[ln] = 1'b0;
                    wait_us(80);
                    for (int b = 39; b >= 0; b--) begin
                        sens_low[ln] = 1'b1;
                        wait_us(20);
                        sens_low[ln] = 1'b0;
                        wait_us(fr[b] ? 60 : 20);
                        mdl_bits++;
                    end
                    sens_low[ln] = 1'b1;
                    wait_us(20);
                    sens_low[ln] = 1'b0;
                    mdl_line = -1;
                end
            end
        end
    end

    initial begin
        int   cyc;
        logic ok;
        int   p_before;
        int   lowc;
        int   seq [5];
        int   done_seen;

        reset        = 1'b1;
        start        = 1'b0;
        auto_scan    = 1'b0;
        sensor_index = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_code", error_code, 2'd0);
        check("rst_index", result_index, 5'd0);
        check("rst_bytes", {hum_int, hum_float, temp_int, temp_float}, 32'h0);
        check("rst_csum", check_sum, 8'h00);
        check("rst_lines", host_low, 4'h0);
        reset = 1'b0;

        // Good read of sensor 3
        go(5'd3);
        check("rd3_busy", busy, 1'b1);
        wait_done(20000, cyc, ok);
        check("rd3_done", ok, 1'b1);
        check("rd3_error", error, 1'b0);
        check("rd3_code", error_code, 2'd0);
        check("rd3_index", result_index, 5'd3);
        check("rd3_hum", {hum_int, hum_float}, 16'h3700);
        check("rd3_temp", {temp_int, temp_float}, 16'h1900);
        check("rd3_csum", check_sum, 8'h50);
        @(negedge clk);
        check("rd3_done_1cyc", done, 1'b0);
        check("rd3_idle", busy, 1'b0);
        check("rd3_hold", hum_int, 8'h37);

        // Silent sensor: three full start pulses, then timeout
        p_before = pulses[2];
        go(5'd2);
        wait_done(20000, cyc, ok);
        check("nr_done", ok, 1'b1);
        check("nr_pulses", pulses[2] - p_before, 3);
        check("nr_pulse_len", bad_len, 0);
        check("nr_error", error, 1'b1);
        check("nr_code", error_code, 2'd1);
        check("nr_index", result_index, 5'd2);
        @(negedge clk);

        // Bad checksum on first attempt, good on retry
        corrupt_once = 1'b1;
        p_before     = pulses[3];
        go(5'd3);
        wait_done(30000, cyc, ok);
        check("ck_done", ok, 1'b1);
        check("ck_pulses", pulses[3] - p_before, 2);
        check("ck_error", error, 1'b0);
        check("ck_code", error_code, 2'd0);
        check("ck_csum", check_sum, 8'h50);
        @(negedge clk);

        // Invalid index: immediate report, no line activity
        lowc = host_low_cyc;
        go(5'd7);
        wait_done(3, cyc, ok);
        check("inv_done", ok, 1'b1);
        check("inv_within3", (cyc <= 2), 1'b1);
        check("inv_code", error_code, 2'd3);
        check("inv_error", error, 1'b1);
        check("inv_index", result_index, 5'd7);
        @(negedge clk);
        check("inv_no_drive", host_low_cyc - lowc, 0);

        // Round-robin scan; a pending start for index 7 must be ignored
        start        = 1'b1;
        sensor_index = 5'd7;
        auto_scan    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_done(20000, cyc, ok);
            check("scan_done", ok, 1'b1);
            seq[k] = int'(result_index);
            if (k == 0) check("scan0_hum", hum_int, 8'h40);
            if (k == 1) check("scan1_temp", temp_float, 8'h08);
            if (k == 2) check("scan2_code", error_code, 2'd1);
            if (k == 4) begin
                auto_scan = 1'b0;
                start     = 1'b0;
            end
            @(negedge clk);
        end
        check("scan_seq0", seq[0], 0);
        check("scan_seq1", seq[1], 1);
        check("scan_seq2", seq[2], 2);
        check("scan_seq3", seq[3], 3);
        check("scan_seq4", seq[4], 0);

        // Reset in the middle of the bit stream
        go(5'd3);
        cyc = 0;
        while (!(mdl_line == 3 && mdl_bits >= 20) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        check("ar_reach_bit20", (cyc < 20000), 1'b1);
        @(negedge clk);
        check("ar_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("ar_busy", busy, 1'b0);
        check("ar_done", done, 1'b0);
        check("ar_lines", host_low, 4'h0);
        check("ar_bytes", {hum_int, hum_float, temp_int, temp_float}, 32'h0);
        check("ar_status", {error, error_code, result_index, check_sum}, 32'h0);
        reset     = 1'b0;
        done_seen = 0;
        repeat (400) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("ar_no_done", done_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
